// File: rtl/line_card_fifo_writer_if.sv
// rtl/line_card_fifo_writer_if.sv - MAC beat stream into the RX FIFO write engine
interface line_card_fifo_writer_if;
  logic        rx_valid;
  logic        rx_ready;
  logic [4:0]  rx_port;
  logic [11:0] rx_vlan;
  logic [63:0] rx_data;
  logic [3:0]  rx_bytes;
  logic        rx_last;
  logic        rx_drop;

  modport master (
    output rx_valid, rx_port, rx_vlan, rx_data, rx_bytes, rx_last, rx_drop,
    input  rx_ready
  );

  modport slave (
    input  rx_valid, rx_port, rx_vlan, rx_data, rx_bytes, rx_last, rx_drop,
    output rx_ready
  );
endinterface

// File: rtl/line_card_fifo_writer.sv
// rtl/line_card_fifo_writer.sv - RX FIFO write engine: per-port framing, header insert, atomic commit
module line_card_fifo_writer #(
  parameter int MAX_FRAME_BYTES = 1536,
  parameter int MIN_FRAME_BYTES = 16
) (
  input  logic                   clk,
  input  logic                   areset_n,
  line_card_fifo_writer_if.slave rx,
  output logic                   wr_en,
  output logic [16:0]            wr_addr,
  output logic [71:0]            wr_data,
  input  logic [12:0]            fifo_wr_free [24],
  output logic [12:0]            fifo_wr_ptr  [24],
  output logic                   drop_en,
  output logic [4:0]             drop_port
);
  localparam int          NPORTS = 24;
  localparam logic [10:0] MAX_B  = 11'(MAX_FRAME_BYTES);
  localparam logic [10:0] MIN_B  = 11'(MIN_FRAME_BYTES);

  typedef enum logic [1:0] {ST_RESET, ST_RUN, ST_HDR} state_t;
  state_t state_q, state_d;

  // Per-port frame assembly state
  logic        act_q   [NPORTS];
  logic        drp_q   [NPORTS];
  logic [12:0] start_q [NPORTS];
  logic [12:0] tent_q  [NPORTS];
  logic [10:0] cnt_q   [NPORTS];
  logic [11:0] vlan_q  [NPORTS];

  // Header write and commit that follow a good last beat
  logic [4:0]  hdr_port_q;
  logic [11:0] hdr_addr_q;
  logic [12:0] hdr_end_q;
  logic [71:0] hdr_word_q;
  logic        pend_q;

  logic        beat, in_range, is_first, drp_eff, bad, bad_last, wr_beat, hdr_go;
  logic [4:0]  idx;
  logic [12:0] commit_eff, start_eff, tent_eff, words;
  logic [10:0] cnt_eff, cnt_new;
  logic [11:0] vlan_eff, sum;

  // Resolve the beat's port context; a commit landing this cycle is bypassed so a new frame starts after it
  always_comb begin
    beat       = rx.rx_valid && rx.rx_ready;
    in_range   = rx.rx_port < 5'd24;
    idx        = in_range ? rx.rx_port : 5'd0;
    commit_eff = (pend_q && hdr_port_q == rx.rx_port) ? hdr_end_q : fifo_wr_ptr[idx];
    is_first   = !act_q[idx];
    start_eff  = is_first ? commit_eff : start_q[idx];
    tent_eff   = is_first ? commit_eff + 13'd1 : tent_q[idx];
    cnt_eff    = is_first ? 11'd0 : cnt_q[idx];
    vlan_eff   = is_first ? rx.rx_vlan : vlan_q[idx];
    drp_eff    = is_first ? 1'b0 : drp_q[idx];
    sum        = {1'b0, cnt_eff} + {8'd0, rx.rx_bytes};
    cnt_new    = sum[11] ? 11'h7FF : sum[10:0];
    words      = tent_eff - start_eff + 13'd1;
    bad        = drp_eff || rx.rx_drop || !in_range ||
                 (words > fifo_wr_free[idx]) || (cnt_new > MAX_B);
    bad_last   = bad || (cnt_new < MIN_B);
    wr_beat    = beat && !bad;
    hdr_go     = beat && rx.rx_last && !bad_last;
  end

  // State register
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) state_q <= ST_RESET;
    else           state_q <= state_d;
  end

  // Next state: one bubble cycle after a good last beat for the header write
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_RUN;
      ST_RUN:   if (hdr_go) state_d = ST_HDR;
      ST_HDR:   state_d = ST_RUN;
      default:  state_d = ST_RESET;
    endcase
  end

  // Beats are accepted only while running and no header write is owed
  always_comb begin
    rx.rx_ready = (state_q == ST_RUN);
  end

  // URAM write port, per-port state, drop reporting and pointer commit
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      for (int i = 0; i < NPORTS; i++) begin
        act_q[i]       <= 1'b0;
        drp_q[i]       <= 1'b0;
        start_q[i]     <= 13'd0;
        tent_q[i]      <= 13'd0;
        cnt_q[i]       <= 11'd0;
        vlan_q[i]      <= 12'd0;
        fifo_wr_ptr[i] <= 13'd0;
      end
      wr_en      <= 1'b0;
      wr_addr    <= 17'd0;
      wr_data    <= 72'd0;
      drop_en    <= 1'b0;
      drop_port  <= 5'd0;
      hdr_port_q <= 5'd0;
      hdr_addr_q <= 12'd0;
      hdr_end_q  <= 13'd0;
      hdr_word_q <= 72'd0;
      pend_q     <= 1'b0;
    end else begin
      wr_en   <= 1'b0;
      drop_en <= 1'b0;
      pend_q  <= 1'b0;
      if (pend_q) fifo_wr_ptr[hdr_port_q] <= hdr_end_q;
      if (state_q == ST_HDR) begin
        wr_en   <= 1'b1;
        wr_addr <= {hdr_port_q, hdr_addr_q};
        wr_data <= hdr_word_q;
        pend_q  <= 1'b1;
      end
      if (beat) begin
        if (wr_beat) begin
          wr_en   <= 1'b1;
          wr_addr <= {rx.rx_port, tent_eff[11:0]};
          wr_data <= {8'h00, rx.rx_data};
        end
        if (in_range) begin
          start_q[idx] <= start_eff;
          cnt_q[idx]   <= cnt_new;
          vlan_q[idx]  <= vlan_eff;
          if (rx.rx_last) begin
            act_q[idx]  <= 1'b0;
            drp_q[idx]  <= 1'b0;
            tent_q[idx] <= bad_last ? start_eff : tent_eff + 13'd1;
          end else begin
            act_q[idx]  <= 1'b1;
            drp_q[idx]  <= bad;
            tent_q[idx] <= bad ? tent_eff : tent_eff + 13'd1;
          end
        end
        if (rx.rx_last && bad_last) begin
          drop_en   <= 1'b1;
          drop_port <= rx.rx_port;
        end
        if (hdr_go) begin
          hdr_port_q <= rx.rx_port;
          hdr_addr_q <= start_eff[11:0];
          hdr_end_q  <= tent_eff + 13'd1;
          hdr_word_q <= {44'd0, vlan_eff, 5'd0, cnt_new};
        end
      end
    end
  end
endmodule

// File: tb/tb_line_card_fifo_writer.sv
// tb/tb_line_card_fifo_writer.sv - directed self-checking bench for line_card_fifo_writer
`timescale 1ns/1ps
module tb_line_card_fifo_writer;
  logic        clk = 1'b0;
  logic        areset_n;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [71:0] wr_data;
  logic [12:0] free [24];
  logic [12:0] ptr  [24];
  logic        drop_en;
  logic [4:0]  drop_port;

  int checks = 0;
  int errors = 0;
  logic [71:0] uram [logic [16:0]];
  logic bub_en = 1'b0;
  int   bubbles = 0;

  line_card_fifo_writer_if rx_if();

  line_card_fifo_writer #(.MAX_FRAME_BYTES(1536), .MIN_FRAME_BYTES(16)) dut (
    .clk          (clk),
    .areset_n     (areset_n),
    .rx           (rx_if),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .fifo_wr_free (free),
    .fifo_wr_ptr  (ptr),
    .drop_en      (drop_en),
    .drop_port    (drop_port)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (areset_n && wr_en) uram[wr_addr] = wr_data;
    if (bub_en && !rx_if.rx_ready) bubbles++;
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pat(input int p, input int b);
    return {16'hD00D, 8'(p), 8'h00, 32'(b)};
  endfunction

  task automatic send_beat(input int p, input logic [11:0] v, input int b, input int nb,
                           input bit last, input bit drp);
    int n;
    n = 0;
    rx_if.rx_valid = 1'b1;
    rx_if.rx_port  = 5'(p);
    rx_if.rx_vlan  = v;
    rx_if.rx_data  = pat(p, b);
    rx_if.rx_bytes = 4'(nb);
    rx_if.rx_last  = last;
    rx_if.rx_drop  = drp;
    while (!rx_if.rx_ready && n < 20) begin
      step();
      n++;
    end
    if (!rx_if.rx_ready) chk("ready_timeout", {71'd0, rx_if.rx_ready}, 72'd1);
    step();
    rx_if.rx_valid = 1'b0;
    rx_if.rx_drop  = 1'b0;
  endtask

  task automatic send_frame(input int p, input logic [11:0] v, input int nbytes, input int drop_beat);
    int nbeats;
    int nb;
    nbeats = (nbytes + 7) / 8;
    for (int b = 0; b < nbeats; b++) begin
      nb = (b == nbeats - 1) ? nbytes - 8 * b : 8;
      send_beat(p, v, b, nb, b == nbeats - 1, b == drop_beat);
    end
  endtask

  task automatic expect_commit(input int p, input int start, input int new_ptr, input logic [71:0] hw);
    chk($sformatf("bubble_p%0d", p), {71'd0, rx_if.rx_ready}, 72'd0);
    chk($sformatf("payload_wr_p%0d", p), {71'd0, wr_en}, 72'd1);
    step();
    chk($sformatf("hdr_wr_en_p%0d", p), {71'd0, wr_en}, 72'd1);
    chk($sformatf("hdr_addr_p%0d", p), {55'd0, wr_addr}, 72'((p << 12) | (start & 4095)));
    chk($sformatf("hdr_data_p%0d", p), wr_data, hw);
    chk($sformatf("ready_back_p%0d", p), {71'd0, rx_if.rx_ready}, 72'd1);
    chk($sformatf("ptr_early_p%0d", p), {59'd0, ptr[p]}, 72'(start));
    step();
    chk($sformatf("ptr_commit_p%0d", p), {59'd0, ptr[p]}, 72'(new_ptr));
  endtask

  task automatic expect_drop(input int p, input int old_ptr);
    chk($sformatf("drop_en_p%0d", p), {71'd0, drop_en}, 72'd1);
    chk($sformatf("drop_port_p%0d", p), {67'd0, drop_port}, 72'(p));
    chk($sformatf("drop_nobubble_p%0d", p), {71'd0, rx_if.rx_ready}, 72'd1);
    step();
    chk($sformatf("drop_pulse_p%0d", p), {71'd0, drop_en}, 72'd0);
    step();
    step();
    chk($sformatf("drop_ptr_p%0d", p), {59'd0, ptr[p]}, 72'(old_ptr));
  endtask

  initial begin
    areset_n       = 1'b0;
    rx_if.rx_valid = 1'b0;
    rx_if.rx_port  = 5'd0;
    rx_if.rx_vlan  = 12'd0;
    rx_if.rx_data  = 64'd0;
    rx_if.rx_bytes = 4'd0;
    rx_if.rx_last  = 1'b0;
    rx_if.rx_drop  = 1'b0;
    for (int i = 0; i < 24; i++) free[i] = 13'd4096;

    // reset values
    #3;
    chk("rst_ready", {71'd0, rx_if.rx_ready}, 72'd0);
    chk("rst_wr_en", {71'd0, wr_en}, 72'd0);
    chk("rst_wr_addr", {55'd0, wr_addr}, 72'd0);
    chk("rst_wr_data", wr_data, 72'd0);
    chk("rst_drop_en", {71'd0, drop_en}, 72'd0);
    chk("rst_drop_port", {67'd0, drop_port}, 72'd0);
    chk("rst_ptr3", {59'd0, ptr[3]}, 72'd0);
    step();
    step();
    areset_n = 1'b1;
    chk("ready_before_edge", {71'd0, rx_if.rx_ready}, 72'd0);
    step();
    chk("ready_after_edge", {71'd0, rx_if.rx_ready}, 72'd1);

    // port 3, 64-byte frame
    send_frame(3, 12'h064, 64, -1);
    expect_commit(3, 0, 9, 72'h0064_0040);
    for (int b = 0; b < 8; b++)
      chk($sformatf("p3_payload%0d", b), uram[17'((3 << 12) | (b + 1))], {8'h00, pat(3, b)});

    // ports 0 and 5 interleaved, 60 bytes each
    bub_en = 1'b1;
    for (int b = 0; b < 8; b++) begin
      send_beat(0, 12'h00A, b, (b == 7) ? 4 : 8, b == 7, 1'b0);
      send_beat(5, 12'h5B5, b, (b == 7) ? 4 : 8, b == 7, 1'b0);
    end
    step();
    step();
    step();
    bub_en = 1'b0;
    chk("interleave_bubbles", 72'(bubbles), 72'd2);
    chk("p0_ptr", {59'd0, ptr[0]}, 72'd9);
    chk("p5_ptr", {59'd0, ptr[5]}, 72'd9);
    chk("p0_hdr", uram[17'h00000], 72'h000A_003C);
    chk("p5_hdr", uram[17'h05000], 72'h05B5_003C);
    for (int b = 0; b < 8; b++) begin
      chk($sformatf("p0_payload%0d", b), uram[17'(b + 1)], {8'h00, pat(0, b)});
      chk($sformatf("p5_payload%0d", b), uram[17'((5 << 12) | (b + 1))], {8'h00, pat(5, b)});
    end

    // port 7 out of space, then a minimum frame fits
    free[7] = 13'd5;
    send_frame(7, 12'h007, 64, -1);
    expect_drop(7, 0);
    send_frame(7, 12'h007, 16, -1);
    expect_commit(7, 0, 3, 72'h0007_0010);
    free[7] = 13'd4096;

    // rx_drop on beat 2 of port 1, retry reuses the start pointer
    send_frame(1, 12'h111, 32, 1);
    expect_drop(1, 0);
    send_frame(1, 12'h112, 16, -1);
    expect_commit(1, 0, 3, 72'h0112_0010);

    // port 2 walked to 4094 with maximum-size frames, then a wrapping frame
    for (int f = 0; f < 21; f++) send_frame(2, 12'h200, 1536, -1);
    send_frame(2, 12'h201, 320, -1);
    step();
    step();
    step();
    chk("p2_ptr_4094", {59'd0, ptr[2]}, 72'd4094);
    send_frame(2, 12'h222, 24, -1);
    expect_commit(2, 4094, 4098, 72'h0222_0018);
    chk("wrap_hdr", uram[17'h02FFE], 72'h0222_0018);
    chk("wrap_pl0", uram[17'h02FFF], {8'h00, pat(2, 0)});
    chk("wrap_pl1", uram[17'h02000], {8'h00, pat(2, 1)});
    chk("wrap_pl2", uram[17'h02001], {8'h00, pat(2, 2)});

    // runt and oversize frames
    send_frame(4, 12'h044, 8, -1);
    expect_drop(4, 0);
    send_frame(6, 12'h066, 1600, -1);
    expect_drop(6, 0);

    // reset in the middle of a port 9 frame
    send_beat(9, 12'h099, 0, 8, 1'b0, 1'b0);
    send_beat(9, 12'h099, 1, 8, 1'b0, 1'b0);
    send_beat(9, 12'h099, 2, 8, 1'b0, 1'b0);
    areset_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", {71'd0, wr_en}, 72'd0);
    chk("mid_rst_wr_addr", {55'd0, wr_addr}, 72'd0);
    chk("mid_rst_wr_data", wr_data, 72'd0);
    chk("mid_rst_ready", {71'd0, rx_if.rx_ready}, 72'd0);
    chk("mid_rst_ptr2", {59'd0, ptr[2]}, 72'd0);
    chk("mid_rst_ptr3", {59'd0, ptr[3]}, 72'd0);
    step();
    areset_n = 1'b1;
    chk("mid_rst_ready_hold", {71'd0, rx_if.rx_ready}, 72'd0);
    step();
    chk("mid_rst_ready_up", {71'd0, rx_if.rx_ready}, 72'd1);
    send_frame(9, 12'h09A, 16, -1);
    expect_commit(9, 0, 3, 72'h009A_0010);
    chk("p9_payload0", uram[17'h09001], {8'h00, pat(9, 0)});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
